mem_resp: RTL and testbench

MEM_RESP -- requirements
Module: mem_resp

---
 rtl/mem_resp_pkg.sv | 17 +
 rtl/mem_array.sv | 24 ++
 rtl/mem_resp.sv | 106 ++++++++++
 tb/tb_mem_resp.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the wait-state memory responder: FSM encodings,
// the default wait-state count and the word-index width helper.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_RESP = 2'd2
    } mem_state_e;

    localparam int unsigned WAIT_CYCLES_DEFAULT = 2;

    function automatic int unsigned word_idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH_WORDS x 32 storage: synchronous write, combinational read.
// Contents are never reset; only a simulation preload can initialise them.
module mem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_resp.sv
// Multicycle-controller memory port: latches a request, inserts WAIT_CYCLES wait
// states, then completes with a one-cycle ready strobe and registered data/err.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int unsigned IW = word_idx_width(DEPTH_WORDS);
    localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES);

    mem_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          we_q;
    logic [IW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          ready_q;
    logic          err_q;

    logic          misaligned;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    logic          unused_addr;

    // Upper address bits are deliberately dropped so accesses wrap modulo the array size.
    assign unused_addr = ^addr[31:IW+2];

    assign misaligned = |addr_q[1:0];
    assign mem_we     = (state_q == MS_RESP) && we_q && !misaligned;

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (IW)
    ) u_mem_array (
        .clk_i  (clk),
        .we_i   (mem_we),
        .addr_i (addr_q[IW+1:2]),
        .wdata_i(wdata_q),
        .rdata_o(mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                MS_IDLE: begin
                    if (req) begin
                        addr_q  <= addr[IW+1:0];
                        we_q    <= we;
                        wdata_q <= wdata;
                        cnt_q   <= CNT_LOAD;
                        state_q <= (WAIT_CYCLES == 0) ? MS_RESP : MS_WAIT;
                    end
                end
                MS_WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    // <= rather than == so a corrupted zero count cannot stall here.
                    if (cnt_q <= CW'(1)) begin
                        state_q <= MS_RESP;
                    end
                end
                MS_RESP: begin
                    ready_q <= 1'b1;
                    err_q   <= misaligned;
                    if (misaligned) begin
                        rdata_q <= '0;
                    end else if (!we_q) begin
                        rdata_q <= mem_rdata;
                    end
                    state_q <= MS_IDLE;
                end
                default: begin
                    state_q <= MS_IDLE;
                end
            endcase
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: directed scenarios plus randomized accesses
// compared against a word-array reference model.
module tb_mem_resp;

    localparam int unsigned WC    = 2;
    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, err;

    logic        req2, we2;
    logic [31:0] addr2, wdata2;
    logic [31:0] rdata2;
    logic        ready2, err2;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    mem_resp #(.WAIT_CYCLES(WC), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err)
    );

    mem_resp #(.WAIT_CYCLES(0), .DEPTH_WORDS(DEPTH)) dut0 (
        .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .rdata(rdata2), .ready(ready2), .err(err2)
    );

    // Reference: misaligned -> err, rdata 0, no store; aligned write stores, rdata held;
    // aligned read returns the stored word. Index wraps modulo DEPTH.
    function automatic void model_access(input logic w, input logic [31:0] a,
                                         input logic [31:0] d,
                                         output logic exp_e, output logic [31:0] exp_r);
        int unsigned idx;
        idx = (a / 4) % DEPTH;
        if (a % 4 != 0) begin
            exp_e = 1'b1;
            exp_r = 32'h0;
        end else if (w) begin
            exp_e = 1'b0;
            model_mem[idx] = d;
            exp_r = exp_rdata;
        end else begin
            exp_e = 1'b0;
            exp_r = model_mem[idx];
        end
        exp_rdata = exp_r;
    endfunction

    // One transaction on dut; inputs are scrambled after the request edge.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic e, output logic [31:0] r,
                       output logic pulse1);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
        lat = -1; e = 1'b0; r = 32'h0; pulse1 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = i; e = err; r = rdata;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            pulse1 = !ready;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        exp_rdata = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({ready, err, rdata} !== 34'h0) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: ready=%b err=%b rdata=%h, required 0/0/0",
                         i, ready, err, rdata);
            end
        end
    endtask

    // Directed access with full comparison against the model.
    task automatic check_access(input string name, input logic w, input logic [31:0] a,
                                input logic [31:0] d);
        int lat; logic e, p; logic [31:0] r; logic exp_e; logic [31:0] exp_r;
        txn(w, a, d, lat, e, r, p);
        model_access(w, a, d, exp_e, exp_r);
        checks++;
        if (lat !== WC + 1) begin
            failures++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, WC + 1);
        end
        checks++;
        if (e !== exp_e) begin
            failures++;
            $display("FAIL %s err: got %b, required %b", name, e, exp_e);
        end
        checks++;
        if (r !== exp_r) begin
            failures++;
            $display("FAIL %s rdata: got %h, required %h", name, r, exp_r);
        end
        checks++;
        if (p !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_pulse: ready still high next cycle, required one cycle", name);
        end
    endtask

    task automatic test_write_read();
        check_access("write_10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        check_access("read_10", 1'b0, 32'h0000_0010, 32'h0);
    endtask

    task automatic test_misaligned();
        check_access("mis_write_13", 1'b1, 32'h0000_0013, 32'h1234_5678);
        check_access("mis_read_22", 1'b0, 32'h0000_0022, 32'h0);
        check_access("read_10_after_mis", 1'b0, 32'h0000_0010, 32'h0);
    endtask

    task automatic test_wrap();
        check_access("wrap_write_1004", 1'b1, 32'h0000_1004, 32'hA5A5_A5A5);
        check_access("wrap_read_4", 1'b0, 32'h0000_0004, 32'h0);
    endtask

    task automatic test_reset_mid_write();
        check_access("pre_write_20", 1'b1, 32'h0000_0020, 32'h1111_2222);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h0000_0020; wdata = 32'h9999_9999;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ready, err, rdata} !== 34'h0) begin
            failures++;
            $display("FAIL async_reset: ready=%b err=%b rdata=%h, required 0/0/0",
                     ready, err, rdata);
        end
        @(negedge clk) rst = 1'b0;
        exp_rdata = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_abandon cycle %0d: ready=%b, required 0", i, ready);
            end
        end
        check_access("read_20_after_reset", 1'b0, 32'h0000_0020, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic w;
        for (int i = 0; i < 16; i++) begin
            a = ($urandom % 8) * 4096 + i * 4;
            check_access("rand_preload", 1'b1, a, $urandom);
        end
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom);
            d = $urandom;
            a = ($urandom % 16) * 4096 + ($urandom % 16) * 4;
            if ($urandom % 4 == 0) a = a + 1 + ($urandom % 3);
            check_access("rand_access", w, a, d);
        end
    endtask

    // WAIT_CYCLES=0 with req held high: ready every other cycle.
    task automatic test_back_to_back();
        logic [31:0] k;
        k = $urandom;
        @(negedge clk);
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h0000_0040; wdata2 = k;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ready2 !== 1'(i % 2)) begin
                failures++;
                $display("FAIL b2b_write ready cycle %0d: got %b, required %b",
                         i, ready2, 1'(i % 2));
            end
        end
        @(negedge clk) we2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ready2 !== 1'(i % 2)) begin
                failures++;
                $display("FAIL b2b_read ready cycle %0d: got %b, required %b",
                         i, ready2, 1'(i % 2));
            end
            if (ready2 === 1'b1) begin
                checks++;
                if ({err2, rdata2} !== {1'b0, k}) begin
                    failures++;
                    $display("FAIL b2b_read data cycle %0d: err=%b rdata=%h, required 0/%h",
                             i, err2, rdata2, k);
                end
            end
        end
        @(negedge clk) req2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready2 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stop: ready=%b after req dropped, required 0", ready2);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_misaligned();
        test_wrap();
        test_reset_mid_write();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
